// File: rtl/di_load_hazard_tracker_if.sv
// Bundle between the PI pipeline / I2 issue side and di_load_hazard_tracker.
// master drives PI status and I2 operands; slave (the tracker) drives the stall view.
interface di_load_hazard_tracker_if #(
   parameter int unsigned REG_ADDR_W = 6,
   parameter int unsigned NUM_I2_RS  = 3,
   parameter int unsigned CNT_W      = 16
);
   logic                             pi_id_ready;
   logic                             pi_ex_ready;
   logic                             pi_wb_ready;
   logic                             pi_data_misaligned;
   logic                             pi_branch_taken_ex;
   logic                             pi_halt_id;
   logic                             pi_load_issue;
   logic [REG_ADDR_W-1:0]            pi_load_rd;
   logic [NUM_I2_RS-1:0]             i2_rs_valid;
   logic [NUM_I2_RS*REG_ADDR_W-1:0]  i2_rs_addr;
   logic                             i2_load_stall_cond;
   logic                             ex_load_valid;
   logic                             wb_load_valid;
   logic [CNT_W-1:0]                 stall_cycle_cnt;

   modport master (
      output pi_id_ready, pi_ex_ready, pi_wb_ready, pi_data_misaligned,
             pi_branch_taken_ex, pi_halt_id, pi_load_issue, pi_load_rd,
             i2_rs_valid, i2_rs_addr,
      input  i2_load_stall_cond, ex_load_valid, wb_load_valid, stall_cycle_cnt
   );

   modport slave (
      input  pi_id_ready, pi_ex_ready, pi_wb_ready, pi_data_misaligned,
             pi_branch_taken_ex, pi_halt_id, pi_load_issue, pi_load_rd,
             i2_rs_valid, i2_rs_addr,
      output i2_load_stall_cond, ex_load_valid, wb_load_valid, stall_cycle_cnt
   );
endinterface

// File: rtl/di_load_hazard_tracker.sv
// Tracks PI loads through EX/WB slots and stalls I2 on a source match.
// Optional macro DI_LOAD_FWD_EN: a WB hit stalls only while WB is held.
module di_load_hazard_tracker #(
   parameter int unsigned REG_ADDR_W = 6,
   parameter int unsigned NUM_I2_RS  = 3,
   parameter int unsigned CNT_W      = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   di_load_hazard_tracker_if.slave  bus
);
   logic                  ex_valid;
   logic [REG_ADDR_W-1:0] ex_rd;
   logic                  wb_valid;
   logic [REG_ADDR_W-1:0] wb_rd;
   logic [CNT_W-1:0]      cnt;

   logic capture;
   logic ex_adv;
   logic wb_release;
   logic wb_fill;
   logic wb_cmp_valid;
   logic stall;

   assign capture    = bus.pi_load_issue & bus.pi_id_ready & ~bus.pi_halt_id &
                       ~bus.pi_branch_taken_ex & (bus.pi_load_rd != '0);
   assign ex_adv     = bus.pi_ex_ready & ex_valid;
   assign wb_release = bus.pi_wb_ready & ~bus.pi_data_misaligned;
   // An empty WB accepts EX even without a release; a held, occupied WB never does.
   assign wb_fill    = ex_adv & (wb_release | ~wb_valid);

`ifdef DI_LOAD_FWD_EN
   assign wb_cmp_valid = wb_valid & ~wb_release;
`else
   assign wb_cmp_valid = wb_valid;
`endif

   always_comb begin
      logic [REG_ADDR_W-1:0] rs;
      stall = 1'b0;
      for (int unsigned k = 0; k < NUM_I2_RS; k++) begin
         rs = bus.i2_rs_addr[k*REG_ADDR_W +: REG_ADDR_W];
         if (bus.i2_rs_valid[k] &&
             ((ex_valid && (rs == ex_rd)) || (wb_cmp_valid && (rs == wb_rd))))
            stall = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_valid <= 1'b0;
         ex_rd    <= '0;
         wb_valid <= 1'b0;
         wb_rd    <= '0;
      end else begin
         if (bus.pi_ex_ready) begin
            ex_valid <= capture;
            if (capture)
               ex_rd <= bus.pi_load_rd;
         end
         if (wb_fill) begin
            wb_valid <= 1'b1;
            wb_rd    <= ex_rd;
         end else if (wb_valid && wb_release) begin
            wb_valid <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         cnt <= '0;
      else if (stall && (cnt != '1))
         cnt <= cnt + 1'b1;
   end

   assign bus.i2_load_stall_cond = stall;
   assign bus.ex_load_valid      = ex_valid;
   assign bus.wb_load_valid      = wb_valid;
   assign bus.stall_cycle_cnt    = cnt;

   a_no_adv_into_held_wb : assert property (
      @(posedge clk) disable iff (rst)
         !(ex_adv && wb_valid && !wb_release)
   );
endmodule

// File: doc/di_load_hazard_tracker.md
# di_load_hazard_tracker

Tracks primary-issue (PI) loads from dispatch through EX and WB and raises `i2_load_stall_cond` whenever a second-issue (I2) instruction sources a register still owed by an in-flight PI load. It sits between the PI ID/EX/WB pipeline and the `i2` side of the dual-issue control interface. It drives the interface's `i2_load_stall_cond` input. It consumes the same PI ready, misalign, branch-kill and halt indications that the interface distributes.

## Interface
Parameters:
- `REG_ADDR_W`, default 6: register address width, covering the integer and FP register files.
- `NUM_I2_RS`, default 3: number of I2 source operands compared.
- `CNT_W`, default 16: width of the stall-cycle counter.

Ports:
- `clk` input, 1: clock. Rising edge only.
- `rst` input, 1: reset. Synchronous, active-high.
- `pi_id_ready` input, 1: PI ID stage hands its instruction to EX this cycle.
- `pi_ex_ready` input, 1: PI EX stage hands its instruction to WB this cycle.
- `pi_wb_ready` input, 1: PI WB stage completes this cycle.
- `pi_data_misaligned` input, 1: PI LSU needs a second access. The WB entry is held.
- `pi_branch_taken_ex` input, 1: taken branch in EX. Kills the ID-to-EX transfer this cycle.
- `pi_halt_id` input, 1: PI ID halted. No dispatch capture.
- `pi_load_issue` input, 1: the instruction leaving PI ID is a load.
- `pi_load_rd` input, REG_ADDR_W: destination of that load.
- `i2_rs_valid` input, NUM_I2_RS: per-operand valid.
- `i2_rs_addr` input, NUM_I2_RS*REG_ADDR_W: packed I2 source addresses. Operand k occupies bits [k*REG_ADDR_W +: REG_ADDR_W].
- `i2_load_stall_cond` output, 1: I2 must stall this cycle.
- `ex_load_valid` output, 1: EX slot occupied.
- `wb_load_valid` output, 1: WB slot occupied.
- `stall_cycle_cnt` output, CNT_W: saturating count of cycles with `i2_load_stall_cond` high.

## Operation
- There are two registered slots, EX and WB. Each holds a valid bit and an rd.
- EX slot capture condition: `pi_load_issue & pi_id_ready & ~pi_halt_id & ~pi_branch_taken_ex & (pi_load_rd != 0)`.
  - A load to register 0 is never tracked.
- EX slot advance: when `pi_ex_ready` and EX is valid, EX moves into WB.
  - If there is no capture in the same cycle, EX clears.
  - If there is a capture in the same cycle, the new load replaces EX. Advance and capture in one cycle are legal.
- EX slot hold: when `~pi_ex_ready`, EX holds and capture is ignored. PI guarantees `pi_id_ready=0` in that case.
- WB slot release: WB clears when `pi_wb_ready & ~pi_data_misaligned`, unless it is refilled from EX in the same cycle.
- WB slot hold: when `~pi_wb_ready` or `pi_data_misaligned`, WB holds.
  - If EX also advances while WB holds, that is a protocol violation. An assertion flags it and WB keeps its old content.
- Hit_k: `i2_rs_valid[k]` and operand k equals the rd of a valid slot.
- Stall condition: `i2_load_stall_cond` is the OR over k of (EX hit) | (WB hit, qualified per the Configuration section).
- Counter: `stall_cycle_cnt` increments on every cycle the stall is high and saturates at all-ones. No wrap.
- Reset: `rst` clears both slots and the counter. The following cycle gives `i2_load_stall_cond=0`, `ex_load_valid=0`, `wb_load_valid=0`, `stall_cycle_cnt=0`. Reset asserted mid-operation discards tracked loads immediately.

## Timing
- Slots update on the rising `clk` edge. A load captured at edge N is visible in `ex_load_valid` and in the stall comparison from cycle N onward.
- `i2_load_stall_cond` is combinational from the registered slots and the current I2 operands. Zero-cycle latency, with no input-to-output path from PI ready signals.
  - Exception: the WB qualification below has that path when DI_LOAD_FWD_EN is defined.
- Minimum load lifetime is 2 cycles (EX then WB). Each held cycle extends it by one.
- Back-to-back loads: 1 load per cycle is sustained with no bubble.

## Configuration
- `DI_LOAD_FWD_EN` defined: a WB hit stalls only while the WB slot is held (`~pi_wb_ready | pi_data_misaligned`). On the completing cycle, write-back data is forwarded to I2 and no stall is raised.
- `DI_LOAD_FWD_EN` undefined: any WB hit stalls, regardless of `pi_wb_ready`.

## Test plan
- Load to x5 dispatched, all readies high, I2 rs1=x5 valid: stall is 1 for 2 cycles, or for 1 cycle when DI_LOAD_FWD_EN is defined. `stall_cycle_cnt` ends at 2 or 1 respectively.
- Load to x0, I2 rs1=x0: stall stays 0 and `ex_load_valid` stays 0.
- Load to x7 dispatched with `pi_branch_taken_ex=1` in the same cycle: nothing captured, and I2 rs2=x7 gives stall 0.
- Load to x9 reaches WB with `pi_data_misaligned=1` for 2 cycles: `wb_load_valid` holds 3 cycles, and stall on rs3=x9 is 1 for all 3, or for 2 when DI_LOAD_FWD_EN is defined.
- Back-to-back loads to x3 then x4, I2 rs1=x4 and rs2=x3: stall is continuous across both lifetimes, with both slots valid simultaneously in cycle 2.
- Force stall for 2^16+5 cycles, then assert `rst` mid-load: counter saturates at 0xFFFF, then all outputs are 0 one cycle after reset.
